// File: rtl/rs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rs_pkg
// Description : Shared types, widths and CDB tag compare for the reservation
//               stations (ALU, MEM, MUL, DIV).
// Revision    : 1.0 - initial release
// ============================================================================
package rs_pkg;

    localparam int XLEN      = 32;  // operand/result width
    localparam int TAG_W     = 4;   // ROB/destination tag width
    localparam int CDB_TAG_W = 8;   // CDB tag width
    localparam int OP_W      = 4;   // ALU operation code width

    // One source operand: ready flag, captured value, producer tag
    typedef struct packed {
        logic              rdy;
        logic [XLEN-1:0]   val;
        logic [TAG_W-1:0]  tag;
    } rs_src_t;

    // One station entry
    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  dst;
        rs_src_t           src1;
        rs_src_t           src2;
    } rs_entry_t;

    // A CDB tag matches only when its bits above TAG_W are all zero
    function automatic logic tag_match(input logic [CDB_TAG_W-1:0] cdb_tag,
                                       input logic [TAG_W-1:0]     tag);
        return (cdb_tag[CDB_TAG_W-1:TAG_W] == '0) && (cdb_tag[TAG_W-1:0] == tag);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rs_age_select.sv
`default_nettype none
// ============================================================================
// Module      : rs_age_select
// Description : Oldest-first one-hot select over an age matrix.
//               older_i[i][j]=1 means entry i is older than entry j.
//               Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_age_select #(
    parameter int NUM_ENTRIES = 4
) (
    input  logic [NUM_ENTRIES-1:0]                  eligible_i,
    input  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] older_i,
    output logic [NUM_ENTRIES-1:0]                  grant_o,
    output logic                                    any_grant_o
);

    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_grant
        logic w_blocked;

        // Entry gi loses if any other eligible entry is older than it
        always_comb begin
            w_blocked = 1'b0;
            for (int j = 0; j < NUM_ENTRIES; j++) begin
                if (j != gi && eligible_i[j] && older_i[j][gi]) begin
                    w_blocked = 1'b1;
                end
            end
        end

        assign grant_o[gi] = eligible_i[gi] && !w_blocked;
    end

    assign any_grant_o = |grant_o;

endmodule
`default_nettype wire

// File: rtl/alu_reservation_station.sv
`default_nettype none
// ============================================================================
// Module      : alu_reservation_station
// Description : Integer ALU reservation station. Holds renamed ops until both
//               sources are ready (CDB snoop + dispatch-time bypass) and issues
//               at most one op per cycle, oldest first, on registered outputs.
//               Operand and tag widths come from rs_pkg (XLEN, TAG_W).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_reservation_station
    import rs_pkg::*;
#(
    parameter int NUM_ENTRIES = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               flush_i,
    input  logic                               dispatch_valid_i,
    output logic                               dispatch_ready_o,
    input  logic [OP_W-1:0]                    dispatch_op_i,
    input  logic [TAG_W-1:0]                   dispatch_tag_i,
    input  logic                               dispatch_src1_ready_i,
    input  logic [XLEN-1:0]                    dispatch_src1_value_i,
    input  logic [TAG_W-1:0]                   dispatch_src1_tag_i,
    input  logic                               dispatch_src2_ready_i,
    input  logic [XLEN-1:0]                    dispatch_src2_value_i,
    input  logic [TAG_W-1:0]                   dispatch_src2_tag_i,
    input  logic                               cdb_valid_i,
    input  logic [CDB_TAG_W-1:0]               cdb_tag_i,
    input  logic [XLEN-1:0]                    cdb_result_i,
    output logic                               alu_valid_o,
    output logic [XLEN-1:0]                    alu_op1_o,
    output logic [XLEN-1:0]                    alu_op2_o,
    output logic [OP_W-1:0]                    alu_operation_o,
    output logic [TAG_W-1:0]                   alu_tag_o,
    output logic [$clog2(NUM_ENTRIES+1)-1:0]   occupancy_o
);

    localparam int CNT_W = $clog2(NUM_ENTRIES + 1);
    localparam int IDX_W = $clog2(NUM_ENTRIES);

    rs_entry_t                              entries_q [NUM_ENTRIES];
    rs_entry_t                              entries_d [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] older_q, older_d;
    logic [CNT_W-1:0]                       occ_q, occ_d;
    logic                                   alu_valid_q, alu_valid_d;
    logic [XLEN-1:0]                        alu_op1_q, alu_op1_d;
    logic [XLEN-1:0]                        alu_op2_q, alu_op2_d;
    logic [OP_W-1:0]                        alu_operation_q, alu_operation_d;
    logic [TAG_W-1:0]                       alu_tag_q, alu_tag_d;

    logic [NUM_ENTRIES-1:0]                 w_eligible;
    logic [NUM_ENTRIES-1:0]                 w_grant;
    logic                                   w_any_grant;
    logic                                   w_dispatch_fire;
    logic [IDX_W-1:0]                       w_free_idx;
    rs_entry_t                              w_new_entry;

    // Ready is based on registered occupancy only; same-cycle frees don't count
    assign dispatch_ready_o = (occ_q < CNT_W'(NUM_ENTRIES));
    assign w_dispatch_fire  = dispatch_valid_i && dispatch_ready_o;

    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_eligible
        assign w_eligible[gi] = entries_q[gi].valid && entries_q[gi].src1.rdy
                                && entries_q[gi].src2.rdy;
    end

    rs_age_select #(
        .NUM_ENTRIES (NUM_ENTRIES)
    ) u_age_select (
        .eligible_i  (w_eligible),
        .older_i     (older_q),
        .grant_o     (w_grant),
        .any_grant_o (w_any_grant)
    );

    // Lowest-index free slot, from registered valid bits
    always_comb begin
        w_free_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!entries_q[i].valid) begin
                w_free_idx = IDX_W'(i);
            end
        end
    end

    // Build the incoming entry, capturing a matching CDB broadcast as a bypass
    always_comb begin
        w_new_entry          = '0;
        w_new_entry.valid    = 1'b1;
        w_new_entry.op       = dispatch_op_i;
        w_new_entry.dst      = dispatch_tag_i;
        w_new_entry.src1.tag = dispatch_src1_tag_i;
        w_new_entry.src2.tag = dispatch_src2_tag_i;
        w_new_entry.src1.rdy = dispatch_src1_ready_i;
        w_new_entry.src1.val = dispatch_src1_value_i;
        w_new_entry.src2.rdy = dispatch_src2_ready_i;
        w_new_entry.src2.val = dispatch_src2_value_i;
        if (!dispatch_src1_ready_i && cdb_valid_i && tag_match(cdb_tag_i, dispatch_src1_tag_i)) begin
            w_new_entry.src1.rdy = 1'b1;
            w_new_entry.src1.val = cdb_result_i;
        end
        if (!dispatch_src2_ready_i && cdb_valid_i && tag_match(cdb_tag_i, dispatch_src2_tag_i)) begin
            w_new_entry.src2.rdy = 1'b1;
            w_new_entry.src2.val = cdb_result_i;
        end
    end

    // Next state: wakeup, issue, dispatch, then flush overrides everything
    always_comb begin
        entries_d       = entries_q;
        older_d         = older_q;
        alu_valid_d     = 1'b0;
        alu_op1_d       = alu_op1_q;
        alu_op2_d       = alu_op2_q;
        alu_operation_d = alu_operation_q;
        alu_tag_d       = alu_tag_q;
        occ_d           = occ_q + CNT_W'(w_dispatch_fire) - CNT_W'(w_any_grant);

        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (entries_q[i].valid && cdb_valid_i) begin
                if (!entries_q[i].src1.rdy && tag_match(cdb_tag_i, entries_q[i].src1.tag)) begin
                    entries_d[i].src1.rdy = 1'b1;
                    entries_d[i].src1.val = cdb_result_i;
                end
                if (!entries_q[i].src2.rdy && tag_match(cdb_tag_i, entries_q[i].src2.tag)) begin
                    entries_d[i].src2.rdy = 1'b1;
                    entries_d[i].src2.val = cdb_result_i;
                end
            end
        end

        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (w_grant[i]) begin
                entries_d[i].valid = 1'b0;
                alu_valid_d        = 1'b1;
                alu_op1_d          = entries_q[i].src1.val;
                alu_op2_d          = entries_q[i].src2.val;
                alu_operation_d    = entries_q[i].op;
                alu_tag_d          = entries_q[i].dst;
                older_d[i]         = '0;
                for (int j = 0; j < NUM_ENTRIES; j++) begin
                    older_d[j][i] = 1'b0;
                end
            end
        end

        // New entry is youngest: every entry surviving this cycle is older
        if (w_dispatch_fire) begin
            entries_d[w_free_idx] = w_new_entry;
            older_d[w_free_idx]   = '0;
            for (int j = 0; j < NUM_ENTRIES; j++) begin
                older_d[j][w_free_idx] = entries_q[j].valid && !w_grant[j];
            end
        end

        if (flush_i) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entries_d[i].valid = 1'b0;
            end
            older_d         = '0;
            occ_d           = '0;
            alu_valid_d     = 1'b0;
            alu_op1_d       = alu_op1_q;
            alu_op2_d       = alu_op2_q;
            alu_operation_d = alu_operation_q;
            alu_tag_d       = alu_tag_q;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entries_q[i] <= '0;
            end
            older_q         <= '0;
            occ_q           <= '0;
            alu_valid_q     <= 1'b0;
            alu_op1_q       <= '0;
            alu_op2_q       <= '0;
            alu_operation_q <= '0;
            alu_tag_q       <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entries_q[i] <= entries_d[i];
            end
            older_q         <= older_d;
            occ_q           <= occ_d;
            alu_valid_q     <= alu_valid_d;
            alu_op1_q       <= alu_op1_d;
            alu_op2_q       <= alu_op2_d;
            alu_operation_q <= alu_operation_d;
            alu_tag_q       <= alu_tag_d;
        end
    end

    assign alu_valid_o     = alu_valid_q;
    assign alu_op1_o       = alu_op1_q;
    assign alu_op2_o       = alu_op2_q;
    assign alu_operation_o = alu_operation_q;
    assign alu_tag_o       = alu_tag_q;
    assign occupancy_o     = occ_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_reservation_station.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_reservation_station
// Description : Scoreboard bench for alu_reservation_station. Stimulus pushes
//               hand-computed expected issues; a negedge monitor pops and
//               compares whenever alu_valid is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_reservation_station;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        dispatch_valid;
    logic        dispatch_ready;
    logic [3:0]  dispatch_op;
    logic [3:0]  dispatch_tag;
    logic        src1_ready, src2_ready;
    logic [31:0] src1_value, src2_value;
    logic [3:0]  src1_tag, src2_tag;
    logic        cdb_valid;
    logic [7:0]  cdb_tag;
    logic [31:0] cdb_result;
    logic        alu_valid;
    logic [31:0] alu_op1, alu_op2;
    logic [3:0]  alu_operation, alu_tag;
    logic [2:0]  occupancy;

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  op;
        logic [3:0]  tag;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    alu_reservation_station #(.NUM_ENTRIES(4)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .flush_i               (flush),
        .dispatch_valid_i      (dispatch_valid),
        .dispatch_ready_o      (dispatch_ready),
        .dispatch_op_i         (dispatch_op),
        .dispatch_tag_i        (dispatch_tag),
        .dispatch_src1_ready_i (src1_ready),
        .dispatch_src1_value_i (src1_value),
        .dispatch_src1_tag_i   (src1_tag),
        .dispatch_src2_ready_i (src2_ready),
        .dispatch_src2_value_i (src2_value),
        .dispatch_src2_tag_i   (src2_tag),
        .cdb_valid_i           (cdb_valid),
        .cdb_tag_i             (cdb_tag),
        .cdb_result_i          (cdb_result),
        .alu_valid_o           (alu_valid),
        .alu_op1_o             (alu_op1),
        .alu_op2_o             (alu_op2),
        .alu_operation_o       (alu_operation),
        .alu_tag_o             (alu_tag),
        .occupancy_o           (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] o1, input logic [31:0] o2,
                        input logic [3:0] op, input logic [3:0] tg);
        exp_t e;
        e.op1 = o1; e.op2 = o2; e.op = op; e.tag = tg;
        sb.push_back(e);
    endtask

    // Inputs presented before a posedge are held across exactly that edge
    task automatic do_dispatch(input logic [3:0] op, input logic [3:0] tg,
                               input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                               input logic r2, input logic [31:0] v2, input logic [3:0] t2);
        dispatch_valid = 1'b1;
        dispatch_op    = op;
        dispatch_tag   = tg;
        src1_ready = r1; src1_value = v1; src1_tag = t1;
        src2_ready = r2; src2_value = v2; src2_tag = t2;
        @(posedge clk); #1;
        dispatch_valid = 1'b0;
    endtask

    task automatic cdb_pulse(input logic [7:0] tg, input logic [31:0] res);
        cdb_valid = 1'b1; cdb_tag = tg; cdb_result = res;
        @(posedge clk); #1;
        cdb_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s actual_pending=%0d required_pending=0", nm, sb.size());
        end
        @(negedge clk);
    endtask

    // Monitor: every issued op must match the oldest outstanding expectation
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && alu_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_issue actual_tag=%0d actual_op1=%h required=no_issue",
                         alu_tag, alu_op1);
            end else begin
                e = sb.pop_front();
                chk("issue_op1", alu_op1, e.op1);
                chk("issue_op2", alu_op2, e.op2);
                chk("issue_operation", {28'd0, alu_operation}, {28'd0, e.op});
                chk("issue_tag", {28'd0, alu_tag}, {28'd0, e.tag});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; dispatch_valid = 1'b0;
        dispatch_op = '0; dispatch_tag = '0;
        src1_ready = 1'b0; src1_value = '0; src1_tag = '0;
        src2_ready = 1'b0; src2_value = '0; src2_tag = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_result = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_alu_valid", {31'd0, alu_valid}, 32'd0);
        chk("rst_occupancy", {29'd0, occupancy}, 32'd0);
        chk("rst_dispatch_ready", {31'd0, dispatch_ready}, 32'd1);
        chk("rst_alu_op1", alu_op1, 32'd0);
        chk("rst_alu_op2", alu_op2, 32'd0);
        chk("rst_alu_tag", {28'd0, alu_tag}, 32'd0);
        chk("rst_alu_operation", {28'd0, alu_operation}, 32'd0);

        // Fully ready op: one bubble, then a single issue cycle
        push(32'd5, 32'd7, 4'h0, 4'd3);
        do_dispatch(4'h0, 4'd3, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0);
        @(negedge clk);
        chk("t1_bubble_valid", {31'd0, alu_valid}, 32'd0);
        chk("t1_occupancy", {29'd0, occupancy}, 32'd1);
        @(negedge clk);
        chk("t1_issue_valid", {31'd0, alu_valid}, 32'd1);
        @(negedge clk);
        chk("t1_after_valid", {31'd0, alu_valid}, 32'd0);
        chk("t1_op1_hold", alu_op1, 32'd5);
        chk("t1_occ_after", {29'd0, occupancy}, 32'd0);

        // src1 waits on tag 9, woken by CDB later
        push(32'hDEAD, 32'h11, 4'h1, 4'd1);
        do_dispatch(4'h1, 4'd1, 1'b0, 32'd0, 4'd9, 1'b1, 32'h11, 4'd0);
        repeat (2) @(negedge clk);
        chk("t2_pending_occ", {29'd0, occupancy}, 32'd1);
        chk("t2_pending_valid", {31'd0, alu_valid}, 32'd0);
        cdb_pulse(8'h09, 32'hDEAD);
        @(negedge clk);
        chk("t2_wake_bubble", {31'd0, alu_valid}, 32'd0);
        @(negedge clk);
        chk("t2_wake_issue", {31'd0, alu_valid}, 32'd1);
        @(negedge clk);

        // Dispatch-time bypass on src2
        push(32'h33, 32'h55, 4'h2, 4'd4);
        cdb_valid = 1'b1; cdb_tag = 8'h02; cdb_result = 32'h55;
        do_dispatch(4'h2, 4'd4, 1'b1, 32'h33, 4'd0, 1'b0, 32'd0, 4'd2);
        cdb_valid = 1'b0;
        drain("t3_bypass_drain");

        // Fill all four entries waiting on tag 6
        for (int i = 0; i < 4; i++) begin
            logic [3:0] opc;
            opc = 4'(3 + i);
            do_dispatch(opc, 4'(i), 1'b0, 32'd0, 4'd6, 1'b1, 32'h100 + 32'(i), 4'd0);
        end
        @(negedge clk);
        chk("t4_full_occ", {29'd0, occupancy}, 32'd4);
        chk("t4_full_ready", {31'd0, dispatch_ready}, 32'd0);

        // Upper CDB tag bits nonzero: must not wake tag 6
        cdb_pulse(8'h16, 32'h77);
        repeat (2) @(negedge clk);
        chk("t5_nowake_occ", {29'd0, occupancy}, 32'd4);

        for (int i = 0; i < 4; i++) begin
            push(32'h66666666, 32'h100 + 32'(i), 4'(3 + i), 4'(i));
        end
        cdb_pulse(8'h06, 32'h66666666);
        @(negedge clk);
        chk("t4_wake_ready", {31'd0, dispatch_ready}, 32'd0);
        chk("t4_wake_occ", {29'd0, occupancy}, 32'd4);
        @(negedge clk);
        chk("t4_first_issue_ready", {31'd0, dispatch_ready}, 32'd1);
        chk("t4_first_issue_occ", {29'd0, occupancy}, 32'd3);
        drain("t4_order_drain");

        // Three ready entries squashed by flush; dispatch in flush cycle dropped
        for (int i = 0; i < 3; i++) begin
            do_dispatch(4'(8 + i), 4'(8 + i), 1'b0, 32'd0, 4'd5, 1'b1, 32'(i), 4'd0);
        end
        cdb_pulse(8'h05, 32'h5A5A);
        flush = 1'b1;
        do_dispatch(4'hC, 4'd12, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0);
        flush = 1'b0;
        @(negedge clk);
        chk("t6_flush_valid", {31'd0, alu_valid}, 32'd0);
        chk("t6_flush_occ", {29'd0, occupancy}, 32'd0);
        chk("t6_flush_ready", {31'd0, dispatch_ready}, 32'd1);
        repeat (5) @(negedge clk);
        chk("t6_post_occ", {29'd0, occupancy}, 32'd0);

        // Station still works after flush
        push(32'hA, 32'hB, 4'hF, 4'd5);
        do_dispatch(4'hF, 4'd5, 1'b1, 32'hA, 4'd0, 1'b1, 32'hB, 4'd0);
        drain("t7_post_flush_drain");

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
